// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared types and helpers for the GPIO interrupt controller.
// GPIO_IRQ_SYNC_EN adds an input synchronizer and lengthens the priming window.
package gpio_irq_pkg;
   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_RISE = 2'd1,
      MODE_FALL = 2'd2,
      MODE_BOTH = 2'd3
   } edge_mode_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } arb_state_t;

`ifdef GPIO_IRQ_SYNC_EN
   localparam int PRIME_CYC = 4;
`else
   localparam int PRIME_CYC = 2;
`endif

   function automatic logic [4:0] lowest_set_idx(input logic [31:0] v);
      lowest_set_idx = '0;
      for (int i = 31; i >= 0; i--)
         if (v[i]) lowest_set_idx = 5'(i);
   endfunction
endpackage

// File: rtl/gpio_irq_edge_unit.sv
// gpio_irq_edge_unit: per-line sampler and mode-selected edge detector.
// GPIO_IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of the sample stage.
module gpio_irq_edge_unit
   import gpio_irq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       line,
   input  edge_mode_t mode,
   input  logic       primed,
   output logic       det
);
   logic src, in_q, prev_q;
`ifdef GPIO_IRQ_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk)
      if (reset) sync_q <= '0;
      else sync_q <= {sync_q[0], line};
   assign src = sync_q[1];
`else
   assign src = line;
`endif
   always_ff @(posedge clk)
      if (reset) begin
         in_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         in_q   <= src;
         prev_q <= in_q;
      end
   assign det = primed & (((mode == MODE_RISE || mode == MODE_BOTH) & in_q & ~prev_q) |
                          ((mode == MODE_FALL || mode == MODE_BOTH) & ~in_q & prev_q));
endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: sticky per-line pending bits with a lowest-index-first claim arbiter.
// GPIO_IRQ_SYNC_EN (see gpio_irq_pkg) enables input synchronizers.
module gpio_irq_ctrl
   import gpio_irq_pkg::*;
#(
   parameter  int NUM_LINES = 8,
   localparam int ID_W      = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_LINES-1:0]   lines_i,
   input  logic [2*NUM_LINES-1:0] mode_i,
   output logic                   irq_valid_o,
   output logic [ID_W-1:0]        irq_id_o,
   input  logic                   irq_ready_i,
   output logic                   irq_o,
   output logic [NUM_LINES-1:0]   pending_o
);
   logic [NUM_LINES-1:0] det, pend_nxt;
   logic [2:0]           prime_cnt;
   logic                 primed, hs;
   arb_state_t           state, state_nxt;
   logic [ID_W-1:0]      id_nxt;

   // Edges are ignored until the sample pipeline has been refilled after reset.
   always_ff @(posedge clk)
      if (reset) prime_cnt <= '0;
      else if (!primed) prime_cnt <= prime_cnt + 3'd1;
   assign primed = prime_cnt == 3'(PRIME_CYC);

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      gpio_irq_edge_unit u_edge (
         .clk    (clk),
         .reset  (reset),
         .line   (lines_i[g]),
         .mode   (edge_mode_t'(mode_i[2*g +: 2])),
         .primed (primed),
         .det    (det[g])
      );
   end

   assign hs          = irq_valid_o & irq_ready_i;
   assign irq_valid_o = state == ST_PRESENT;

   always_comb begin
      pend_nxt = pending_o;
      for (int i = 0; i < NUM_LINES; i++)
         pend_nxt[i] = (mode_i[2*i +: 2] == MODE_OFF)     ? 1'b0 :
                       det[i]                             ? 1'b1 :
                       (hs && int'(irq_id_o) == i)        ? 1'b0 : pending_o[i];
   end

   // A presented line whose pending bit is about to vanish (mode OFF) is withdrawn.
   always_comb begin
      state_nxt = state;
      id_nxt    = irq_id_o;
      if (state == ST_IDLE) begin
         if (|pending_o) begin
            state_nxt = ST_PRESENT;
            id_nxt    = ID_W'(lowest_set_idx(32'(pending_o)));
         end
      end else if (hs || !pend_nxt[irq_id_o]) begin
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk)
      if (reset) begin
         pending_o <= '0;
         irq_o     <= 1'b0;
         state     <= ST_IDLE;
         irq_id_o  <= '0;
      end else begin
         pending_o <= pend_nxt;
         irq_o     <= |pending_o;
         state     <= state_nxt;
         irq_id_o  <= id_nxt;
      end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl: directed stimulus with a presentation scoreboard for gpio_irq_ctrl.
module tb_gpio_irq_ctrl;
`ifdef GPIO_IRQ_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif
   logic        clk = 0, reset = 1, irq_ready_i = 0;
   logic [7:0]  lines_i = 8'hFF;
   logic [15:0] mode_i = 16'h5555;
   logic        irq_valid_o, irq_o;
   logic [2:0]  irq_id_o;
   logic [7:0]  pending_o;
   int          n_cmp = 0, n_err = 0;
   int          exp_q[$];
   logic        prev_v = 0;
   logic [2:0]  prev_id = 0;

   gpio_irq_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .lines_i     (lines_i),
      .mode_i      (mode_i),
      .irq_valid_o (irq_valid_o),
      .irq_id_o    (irq_id_o),
      .irq_ready_i (irq_ready_i),
      .irq_o       (irq_o),
      .pending_o   (pending_o)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic claim();
      irq_ready_i = 1;
      tick(1);
      irq_ready_i = 0;
   endtask

   // Monitor: each new presentation pops the scoreboard; held presentations must not change id.
   always @(negedge clk) begin
      if (irq_valid_o) begin
         n_cmp++;
         if (!prev_v) begin
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL present: got id %0d expected no presentation", irq_id_o);
            end else begin
               int e;
               e = exp_q.pop_front();
               if (int'(irq_id_o) != e) begin
                  n_err++;
                  $display("FAIL present: got id %0d expected %0d", irq_id_o, e);
               end
            end
         end else if (irq_id_o !== prev_id) begin
            n_err++;
            $display("FAIL hold: got id %0d expected %0d", irq_id_o, prev_id);
         end
      end
      prev_v  = irq_valid_o;
      prev_id = irq_id_o;
   end

   initial begin
      tick(3);
      chk("rst_pending", pending_o, 0);
      chk("rst_valid", irq_valid_o, 0);
      chk("rst_id", irq_id_o, 0);
      chk("rst_irq", irq_o, 0);
      reset = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("prime_pending", pending_o, 0);
         chk("prime_valid", irq_valid_o, 0);
      end

      // single rising edge on line 3
      lines_i = 8'h00;
      mode_i  = 16'h0040;
      tick(4);
      chk("idle_pending", pending_o, 0);
      exp_q.push_back(3);
      lines_i = 8'h08;
      tick(1 + S);
      chk("l3_pending_early", pending_o, 8'h00);
      tick(1);
      chk("l3_pending", pending_o, 8'h08);
      chk("l3_valid_early", irq_valid_o, 0);
      tick(1);
      chk("l3_valid", irq_valid_o, 1);
      chk("l3_id", irq_id_o, 3);
      chk("l3_irq", irq_o, 1);
      claim();
      chk("l3_claim_pending", pending_o, 0);
      chk("l3_claim_valid", irq_valid_o, 0);
      tick(1);
      chk("l3_irq_drop", irq_o, 0);

      // lines 2 and 5 together, line 0 fires during the presentation
      mode_i  = 16'h0C31;
      exp_q.push_back(2);
      lines_i = 8'h2C;
      tick(2 + S);
      chk("l25_pending", pending_o, 8'h24);
      tick(1);
      chk("l25_id", irq_id_o, 2);
      exp_q.push_back(0);
      exp_q.push_back(5);
      lines_i = 8'h2D;
      tick(3 + S);
      chk("l0_pending", pending_o, 8'h25);
      chk("l2_held", irq_id_o, 2);
      claim();
      chk("l2_claim_valid", irq_valid_o, 0);
      chk("l2_claim_pending", pending_o, 8'h21);
      tick(1);
      chk("l0_id", irq_id_o, 0);
      claim();
      tick(1);
      chk("l5_id", irq_id_o, 5);
      claim();
      chk("l5_claim_pending", pending_o, 0);

      // line 1 falling edge coincident with its own claim
      mode_i  = 16'h0008;
      lines_i = 8'h2F;
      tick(4 + S);
      chk("l1_rise_ignored", pending_o, 0);
      exp_q.push_back(1);
      lines_i = 8'h2D;
      tick(3 + S);
      chk("l1_id", irq_id_o, 1);
      lines_i = 8'h2F;
      tick(3 + S);
      exp_q.push_back(1);
      lines_i = 8'h2D;
      tick(1 + S);
      claim();
      chk("l1_set_wins", pending_o, 8'h02);
      chk("l1_idle_gap", irq_valid_o, 0);
      tick(1);
      chk("l1_represent", irq_valid_o, 1);
      claim();
      chk("l1_final_pending", pending_o, 0);

      // line 4 withdrawn by mode OFF
      mode_i  = 16'h0100;
      exp_q.push_back(4);
      lines_i = 8'h3D;
      tick(3 + S);
      chk("l4_id", irq_id_o, 4);
      mode_i = 16'h0000;
      tick(1);
      chk("l4_off_pending", pending_o, 0);
      chk("l4_off_valid", irq_valid_o, 0);
      tick(2);
      chk("l4_stays_idle", irq_valid_o, 0);

      // reset mid-operation loses pending edges and re-primes
      mode_i  = 16'h0300;
      lines_i = 8'h2D;
      tick(2 + S);
      chk("mid_pending", pending_o, 8'h10);
      chk("mid_irq_delay", irq_o, 0);
      reset = 1;
      tick(1);
      chk("mid_rst_pending", pending_o, 0);
      chk("mid_rst_valid", irq_valid_o, 0);
      chk("mid_rst_irq", irq_o, 0);
      reset = 0;
      tick(8);
      chk("post_rst_pending", pending_o, 0);
      exp_q.push_back(4);
      lines_i = 8'h3D;
      tick(3 + S);
      chk("post_rst_id", irq_id_o, 4);
      claim();
      tick(3);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
